// File: rtl/mod_exp_mr_core_if.sv
`default_nettype none
// ============================================================================
// mod_exp_mr_core_if : operand/result handshake bundle for mod_exp_mr_core
// Rev 1.0 - initial release
// ============================================================================
interface mod_exp_mr_core_if #(
  parameter int BIT_LENGTH = 128,
  parameter int R_WIDTH    = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [BIT_LENGTH-1:0] p_value;
  logic [BIT_LENGTH-1:0] a_value;
  logic                  o_valid;
  logic                  o_ready;
  logic [BIT_LENGTH-1:0] m_value;
  logic [R_WIDTH-1:0]    r_value;
  logic [BIT_LENGTH-1:0] x_value;
  logic                  prime_flag;
  logic                  error;

  modport master (
    output s_valid, p_value, a_value, o_ready,
    input  s_ready, o_valid, m_value, r_value, x_value, prime_flag, error
  );

  modport slave (
    input  s_valid, p_value, a_value, o_ready,
    output s_ready, o_valid, m_value, r_value, x_value, prime_flag, error
  );
endinterface
`default_nettype wire

// File: rtl/mod_exp_mr_core.sv
`default_nettype none
// ============================================================================
// mod_exp_mr_core : p-1 = m*2^r decomposition, x = a^m mod p via a bit-serial
// interleaved multiplier, optional Miller-Rabin verdict (macro MR_VERDICT_EN).
// Rev 1.0 - initial release
// ============================================================================
module mod_exp_mr_core #(
  parameter int BIT_LENGTH = 128,
  parameter int R_WIDTH    = 8
) (
  input  wire logic          aclk,
  input  wire logic          aresetn,
  mod_exp_mr_core_if.slave   bus
);

  localparam int                    CNT_W    = $clog2(BIT_LENGTH);
  localparam logic [CNT_W-1:0]      CNT_INIT = CNT_W'(BIT_LENGTH - 1);
  localparam logic [BIT_LENGTH-1:0] ONE      = BIT_LENGTH'(1);
  localparam logic [BIT_LENGTH-1:0] ZERO     = '0;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CHECK    = 4'd1,
    ST_DECOMP   = 4'd2,
    ST_REDUCE   = 4'd3,
    ST_REDUCE_W = 4'd4,
    ST_EXP      = 4'd5,
    ST_EXP_MUL  = 4'd6,
    ST_EXP_NEXT = 4'd7,
    ST_EXP_SQR  = 4'd8,
    ST_VERDICT  = 4'd9,
    ST_VER_SQR  = 4'd10,
    ST_DONE     = 4'd11
  } state_t;

  state_t                state;
  logic [BIT_LENGTH-1:0] p_reg;
  logic [BIT_LENGTH-1:0] a_reg;
  logic [BIT_LENGTH-1:0] m_reg;
  logic [R_WIDTH-1:0]    r_reg;
  logic [BIT_LENGTH-1:0] x_reg;
  logic [BIT_LENGTH-1:0] base;
  logic [BIT_LENGTH-1:0] acc;
  logic [BIT_LENGTH-1:0] e_reg;
  logic                  s_ready_r;
  logic                  o_valid_r;
  logic                  error_r;

  logic                  mul_run;
  logic [CNT_W-1:0]      mul_cnt;
  logic [BIT_LENGTH-1:0] mul_x;
  logic [BIT_LENGTH-1:0] mul_y;
  logic [BIT_LENGTH-1:0] mul_acc;
  logic [BIT_LENGTH-1:0] mul_next;
  logic [BIT_LENGTH-1:0] pm1;

`ifdef MR_VERDICT_EN
  logic                  prime_r;
  logic [BIT_LENGTH-1:0] vx;
  logic [R_WIDTH-1:0]    sq_cnt;
`endif

  assign pm1 = p_reg - ONE;

  // One Horner step: 2R + bit*Y is below 3p, so two trial subtractions suffice.
  always_comb begin
    logic [BIT_LENGTH+1:0] p_ext;
    logic [BIT_LENGTH+1:0] sum0;
    logic [BIT_LENGTH+1:0] sum1;
    p_ext    = {2'b00, p_reg};
    sum0     = {1'b0, mul_acc, 1'b0} + (mul_x[BIT_LENGTH-1] ? {2'b00, mul_y} : '0);
    sum1     = (sum0 >= p_ext) ? (sum0 - p_ext) : sum0;
    mul_next = (sum1 >= p_ext) ? BIT_LENGTH'(sum1 - p_ext) : BIT_LENGTH'(sum1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      s_ready_r <= 1'b1;
      o_valid_r <= 1'b0;
      error_r   <= 1'b0;
      m_reg     <= '0;
      r_reg     <= '0;
      x_reg     <= '0;
      mul_run   <= 1'b0;
      mul_cnt   <= '0;
`ifdef MR_VERDICT_EN
      prime_r   <= 1'b0;
`endif
    end else begin
      if (mul_run) begin
        mul_acc <= mul_next;
        mul_x   <= mul_x << 1;
        if (mul_cnt == '0) mul_run <= 1'b0;
        else               mul_cnt <= mul_cnt - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (bus.s_valid) begin
            p_reg     <= bus.p_value;
            a_reg     <= bus.a_value;
            s_ready_r <= 1'b0;
            state     <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          x_reg <= '0;
          r_reg <= '0;
`ifdef MR_VERDICT_EN
          prime_r <= 1'b0;
`endif
          if (!p_reg[0] || p_reg < BIT_LENGTH'(3)) begin
            error_r   <= 1'b1;
            m_reg     <= '0;
            o_valid_r <= 1'b1;
            state     <= ST_DONE;
          end else begin
            error_r <= 1'b0;
            m_reg   <= pm1;
            state   <= ST_DECOMP;
          end
        end
        ST_DECOMP: begin
          if (!m_reg[0]) begin
            m_reg <= m_reg >> 1;
            r_reg <= r_reg + 1'b1;
          end else begin
            state <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          {mul_run, mul_cnt, mul_acc, mul_x, mul_y} <= {1'b1, CNT_INIT, ZERO, a_reg, ONE};
          state <= ST_REDUCE_W;
        end
        ST_REDUCE_W: begin
          if (!mul_run) begin
            base  <= mul_acc;
            acc   <= ONE;
            e_reg <= m_reg;
            state <= ST_EXP;
          end
        end
        ST_EXP: begin
          if (e_reg[0]) begin
            {mul_run, mul_cnt, mul_acc, mul_x, mul_y} <= {1'b1, CNT_INIT, ZERO, acc, base};
            state <= ST_EXP_MUL;
          end else begin
            state <= ST_EXP_NEXT;
          end
        end
        ST_EXP_MUL: begin
          if (!mul_run) begin
            acc   <= mul_acc;
            state <= ST_EXP_NEXT;
          end
        end
        ST_EXP_NEXT: begin
          if (e_reg > ONE) begin
            {mul_run, mul_cnt, mul_acc, mul_x, mul_y} <= {1'b1, CNT_INIT, ZERO, base, base};
            state <= ST_EXP_SQR;
          end else begin
            x_reg <= acc;
`ifdef MR_VERDICT_EN
            vx     <= acc;
            sq_cnt <= r_reg - 1'b1;
            state  <= ST_VERDICT;
`else
            o_valid_r <= 1'b1;
            state     <= ST_DONE;
`endif
          end
        end
        ST_EXP_SQR: begin
          if (!mul_run) begin
            base  <= mul_acc;
            e_reg <= e_reg >> 1;
            state <= ST_EXP;
          end
        end
`ifdef MR_VERDICT_EN
        ST_VERDICT: begin
          if (vx == ONE || vx == pm1) begin
            prime_r   <= 1'b1;
            o_valid_r <= 1'b1;
            state     <= ST_DONE;
          end else if (sq_cnt == '0) begin
            prime_r   <= 1'b0;
            o_valid_r <= 1'b1;
            state     <= ST_DONE;
          end else begin
            {mul_run, mul_cnt, mul_acc, mul_x, mul_y} <= {1'b1, CNT_INIT, ZERO, vx, vx};
            sq_cnt <= sq_cnt - 1'b1;
            state  <= ST_VER_SQR;
          end
        end
        ST_VER_SQR: begin
          // Neither 1 nor p-1 after a square: fall back to VERDICT for the budget test.
          if (!mul_run) begin
            vx <= mul_acc;
            if (mul_acc == pm1 || mul_acc == ONE) begin
              prime_r   <= (mul_acc == pm1);
              o_valid_r <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_VERDICT;
            end
          end
        end
`endif
        ST_DONE: begin
          if (bus.o_ready) begin
            o_valid_r <= 1'b0;
            s_ready_r <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready = s_ready_r;
  assign bus.o_valid = o_valid_r;
  assign bus.m_value = m_reg;
  assign bus.r_value = r_reg;
  assign bus.x_value = x_reg;
  assign bus.error   = error_r;
`ifdef MR_VERDICT_EN
  assign bus.prime_flag = prime_r;
`else
  assign bus.prime_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_exp_mr_core.sv
`default_nettype none
// ============================================================================
// tb_mod_exp_mr_core : randomized + directed bench for mod_exp_mr_core
// Rev 1.0 - initial release
// ============================================================================
module tb_mod_exp_mr_core;

  localparam int BL    = 16;
  localparam int RW    = 5;
  localparam int LIMIT = 5000;
`ifdef MR_VERDICT_EN
  localparam bit PF13 = 1'b1;
`else
  localparam bit PF13 = 1'b0;
`endif

  typedef struct packed {
    logic [BL-1:0] m;
    logic [RW-1:0] r;
    logic [BL-1:0] x;
    logic          pf;
    logic          err;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   post_xfer = 1'b0;
  bit   abort = 1'b0;
  exp_t q[$];

  mod_exp_mr_core_if #(.BIT_LENGTH(BL), .R_WIDTH(RW)) bus ();

  mod_exp_mr_core #(.BIT_LENGTH(BL), .R_WIDTH(RW)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  always #5 aclk = ~aclk;

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference: plain integer arithmetic on the Miller-Rabin definitions.
  function automatic exp_t model(input logic [BL-1:0] p, input logic [BL-1:0] a);
    exp_t   e;
    longint pl, mm, rr, b, acc, ee, y;
    e  = '0;
    pl = longint'(p);
    if (pl % 2 == 0 || pl < 3) begin
      e.err = 1'b1;
      return e;
    end
    mm = pl - 1;
    rr = 0;
    while (mm % 2 == 0) begin
      mm = mm / 2;
      rr++;
    end
    b   = longint'(a) % pl;
    acc = 1;
    ee  = mm;
    while (ee > 0) begin
      if (ee % 2 == 1) acc = (acc * b) % pl;
      b  = (b * b) % pl;
      ee = ee / 2;
    end
    e.m = mm[BL-1:0];
    e.r = rr[RW-1:0];
    e.x = acc[BL-1:0];
`ifdef MR_VERDICT_EN
    if (acc == 1 || acc == pl - 1) begin
      e.pf = 1'b1;
    end else begin
      y = acc;
      for (longint i = 1; i < rr; i++) begin
        y = (y * y) % pl;
        if (y == pl - 1) begin
          e.pf = 1'b1;
          break;
        end
        if (y == 1) break;
      end
    end
`endif
    return e;
  endfunction

  // Output checker: every cycle o_valid is high the result must match the head expectation.
  always @(negedge aclk) begin
    if (mon_en && aresetn) begin
      if (post_xfer)
        check(!bus.o_valid && bus.s_ready, "post_transfer",
              $sformatf("got o_valid=%0b s_ready=%0b want 0/1", bus.o_valid, bus.s_ready));
      post_xfer = 1'b0;
      if (bus.o_valid) begin
        exp_t got;
        got = '{m: bus.m_value, r: bus.r_value, x: bus.x_value, pf: bus.prime_flag, err: bus.error};
        if (q.size() == 0) begin
          check(1'b0, "unexpected_output", $sformatf("got %h want no output", got));
        end else begin
          check(got == q[0], "result",
                $sformatf("got m=%0d r=%0d x=%0d pf=%0b err=%0b want m=%0d r=%0d x=%0d pf=%0b err=%0b",
                          got.m, got.r, got.x, got.pf, got.err,
                          q[0].m, q[0].r, q[0].x, q[0].pf, q[0].err));
          check(!bus.s_ready, "s_ready_busy", $sformatf("got %0b want 0", bus.s_ready));
          if (bus.o_ready) begin
            void'(q.pop_front());
            post_xfer = 1'b1;
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    mon_en      = 1'b0;
    aresetn     = 1'b0;
    bus.s_valid = 1'b0;
    bus.o_ready = 1'b0;
    repeat (2) cycle();
    aresetn   = 1'b1;
    q.delete();
    post_xfer = 1'b0;
    mon_en    = 1'b1;
  endtask

  task automatic send(input logic [BL-1:0] p, input logic [BL-1:0] a, input exp_t e);
    int n = 0;
    while (!bus.s_ready && n < LIMIT) begin
      cycle();
      n++;
    end
    if (!bus.s_ready) begin
      check(1'b0, "s_ready_timeout", $sformatf("got s_ready=0 want 1 within %0d cycles", LIMIT));
      abort = 1'b1;
      do_reset();
    end
    bus.p_value = p;
    bus.a_value = a;
    bus.s_valid = 1'b1;
    q.push_back(e);
    cycle();
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.o_valid && n < LIMIT) begin
      cycle();
      n++;
    end
    if (!bus.o_valid) begin
      check(1'b0, "o_valid_timeout", $sformatf("got o_valid=0 want 1 within %0d cycles", LIMIT));
      abort = 1'b1;
      do_reset();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < LIMIT) begin
      cycle();
      n++;
    end
    if (q.size() != 0) begin
      check(1'b0, "drain_timeout", $sformatf("got %0d pending want 0", q.size()));
      abort = 1'b1;
      do_reset();
    end
    cycle();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish want finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin : main
    exp_t e13, e561, e10, e15, m;
    logic [BL-1:0] p, a;
    int n;

    e13  = '{m: 16'd3,  r: 5'd2, x: 16'd8,   pf: PF13, err: 1'b0};
    e561 = '{m: 16'd35, r: 5'd4, x: 16'd263, pf: 1'b0, err: 1'b0};
    e10  = '{m: 16'd0,  r: 5'd0, x: 16'd0,   pf: 1'b0, err: 1'b1};
    e15  = '{m: 16'd7,  r: 5'd1, x: 16'd8,   pf: 1'b0, err: 1'b0};

    m = model(16'd13, 16'd2);
    check(m == e13, "model_p13", $sformatf("got %h want %h", m, e13));
    m = model(16'd561, 16'd2);
    check(m == e561, "model_p561", $sformatf("got %h want %h", m, e561));
    m = model(16'd10, 16'd3);
    check(m == e10, "model_p10", $sformatf("got %h want %h", m, e10));

    aresetn     = 1'b0;
    bus.s_valid = 1'b0;
    bus.o_ready = 1'b0;
    bus.p_value = '0;
    bus.a_value = '0;
    repeat (3) cycle();
    check(bus.s_ready && !bus.o_valid && bus.m_value == 0 && bus.r_value == 0 &&
          bus.x_value == 0 && !bus.prime_flag && !bus.error, "reset_state",
          $sformatf("got s_ready=%0b o_valid=%0b m=%0d r=%0d x=%0d pf=%0b err=%0b want 1/0/0/0/0/0/0",
                    bus.s_ready, bus.o_valid, bus.m_value, bus.r_value, bus.x_value,
                    bus.prime_flag, bus.error));
    aresetn = 1'b1;
    mon_en  = 1'b1;
    cycle();

    bus.o_ready = 1'b1;
    send(16'd13, 16'd2, e13);   wait_idle();
    send(16'd561, 16'd2, e561); wait_idle();
    send(16'd13, 16'd28, e13);  wait_idle();
    send(16'd3, 16'd2, model(16'd3, 16'd2)); wait_idle();
    send(16'd13, 16'd26, model(16'd13, 16'd26)); wait_idle();

    send(16'd10, 16'd3, e10);
    n = 0;
    while (!bus.o_valid && n < 10) begin
      cycle();
      n++;
    end
    check(bus.o_valid && n <= 3, "error_latency", $sformatf("got %0d cycles want <=3", n));
    wait_idle();

    // Back-pressure with ignored s_valid pulses while busy.
    bus.o_ready = 1'b0;
    send(16'd15, 16'd2, e15);
    bus.p_value = 16'd13;
    bus.a_value = 16'd2;
    bus.s_valid = 1'b1;
    cycle();
    bus.s_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      check(!bus.s_ready && bus.o_valid, "hold_busy",
            $sformatf("got s_ready=%0b o_valid=%0b want 0/1", bus.s_ready, bus.o_valid));
      bus.s_valid = (i == 5);
      cycle();
    end
    bus.s_valid = 1'b0;
    bus.o_ready = 1'b1;
    wait_idle();
    repeat (5) cycle();

    // Reset in the middle of exponentiation.
    send(16'd65521, 16'd12345, model(16'd65521, 16'd12345));
    repeat (40) cycle();
    mon_en  = 1'b0;
    aresetn = 1'b0;
    cycle();
    check(bus.s_ready && !bus.o_valid && bus.m_value == 0 && bus.r_value == 0 &&
          bus.x_value == 0 && !bus.prime_flag && !bus.error, "mid_exp_reset",
          $sformatf("got s_ready=%0b o_valid=%0b m=%0d r=%0d x=%0d pf=%0b err=%0b want 1/0/0/0/0/0/0",
                    bus.s_ready, bus.o_valid, bus.m_value, bus.r_value, bus.x_value,
                    bus.prime_flag, bus.error));
    aresetn   = 1'b1;
    q.delete();
    post_xfer = 1'b0;
    mon_en    = 1'b1;
    send(16'd13, 16'd2, e13);
    wait_idle();

    for (int i = 0; i < 40 && !abort; i++) begin
      int mode = $urandom_range(0, 9);
      int hold = $urandom_range(0, 3);
      p = BL'($urandom_range(3, 65535)) | 16'd1;
      a = BL'($urandom);
      if (mode == 0) p = BL'($urandom) & 16'hFFFE;
      if (mode == 1) p = 16'd1;
      if (mode == 2) a = p;
      if (mode == 3) a = '0;
      bus.o_ready = 1'b0;
      send(p, a, model(p, a));
      wait_valid();
      repeat (hold) cycle();
      bus.o_ready = 1'b1;
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_exp_mr_core.md
Name: mod_exp_mr_core

Overview:
- Parametrised successor to the p-1 decomposition / modular-power block, forming one Miller-Rabin witness round in the RNG prime-test path.
- Accepts odd modulus p and base a over a valid/ready handshake.
- Decomposes p-1 = m*2^r, computes x = a^m mod p with a single bit-serial interleaved modular multiplier, and optionally produces a probable-prime verdict.
- Contains no wide multipliers or dividers; every modular product takes BIT_LENGTH cycles.

Parameters:
- BIT_LENGTH, 128: width of p, a, m and x.
- R_WIDTH, 8: width of r; must satisfy 2^R_WIDTH > BIT_LENGTH.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- s_valid  in  1  input operands valid
- s_ready  out  1  block idle and able to accept operands
- p_value  in  BIT_LENGTH  modulus, must be odd and >= 3
- a_value  in  BIT_LENGTH  base, any value; reduced mod p internally
- o_valid  out  1  result valid
- o_ready  in  1  result consumed
- m_value  out  BIT_LENGTH  odd part of p-1
- r_value  out  R_WIDTH  power of two in p-1
- x_value  out  BIT_LENGTH  a^m mod p
- prime_flag  out  1  probable prime for this witness
- error  out  1  illegal p

Behaviour:
- Reset: all outputs 0 except s_ready=1. State returns to IDLE. Any in-flight computation is abandoned with no output.
- Handshake:
  - Input accepted on the cycle where s_valid && s_ready. p and a are registered; s_ready drops the next cycle.
  - s_ready stays 0 until the output transfer completes.
  - Outputs are held stable while o_valid && !o_ready.
  - On o_valid && o_ready, the next cycle has o_valid=0 and s_ready=1.
- MULMOD engine, computes R = X*Y mod p with Y < p:
  - R starts at 0 and scans X from MSB to LSB, one bit per cycle: R = 2R + bit*Y, followed by up to two conditional subtractions of p.
  - Takes exactly BIT_LENGTH cycles.
  - Internal sum width is BIT_LENGTH+2.
- States:
  - IDLE: on accept, go to CHECK.
  - CHECK: if p[0]==0 or p<3, set error=1, m=0, r=0, x=0, prime_flag=0, and go to DONE. Otherwise load m=p-1, r=0, and go to DECOMP.
  - DECOMP: one cycle per step. While m[0]==0: m>>=1, r++. Go to REDUCE when m is odd.
  - REDUCE: base = MULMOD(X=a, Y=1), which equals a mod p. Set acc=1 and e=m.
  - EXP: right-to-left square-and-multiply.
    - If e[0]: acc = MULMOD(acc, base).
    - If e>1: base = MULMOD(base, base). The final square is skipped.
    - e >>= 1. When e==0, x=acc and go to VERDICT or DONE.
  - VERDICT: see Optional Feature.
  - DONE: o_valid=1; wait for o_ready, then go to IDLE.
- Boundaries:
  - a ≡ 0 mod p gives x=0 and prime_flag=0.
  - p=3 gives m=1, r=1.
  - s_valid asserted while busy is ignored; the operands are not captured.

Optional Feature:
- Macro MR_VERDICT_EN.
- When defined, VERDICT runs:
  - If x==1 or x==p-1: prime_flag=1.
  - Otherwise, up to r-1 times: x = MULMOD(x, x).
    - If x==p-1: prime_flag=1, stop.
    - If x==1: prime_flag=0, stop.
  - If the loop exhausts: prime_flag=0.
  - x_value reports the value before squaring, i.e. a^m mod p.
- When not defined: VERDICT is not synthesised, EXP goes directly to DONE, and prime_flag is tied 0.

Test Plan:
- p=13, a=2 -> m=3, r=2, x=8, error=0, prime_flag=1 (with MR_VERDICT_EN; 0 without).
- p=561, a=2 -> m=35, r=4, x=263, prime_flag=0 (square chain 166, 67, 1).
- p=13, a=28 -> identical outputs to the a=2 case, confirming pre-reduction.
- p=10, a=3 -> error=1, m=0, r=0, x=0, prime_flag=0; o_valid within 3 cycles of accept.
- p=15, a=2 with o_ready held 0 for 20 cycles -> m=7, r=1, x=8. Outputs stable while held, s_ready=0 throughout, and the s_valid pulse during busy is ignored.
- Reset asserted mid-EXP -> next cycle all outputs 0 and s_ready=1; a new p=13, a=2 request then yields x=8.
